// File: rtl/seq_detect_ctrl_if.sv
// Host-side job/status bundle of the sequence detector run controller.
// The host drives jobs through the master modport; the controller answers through the slave modport.
`timescale 1ns/1ps
interface seq_detect_ctrl_if #(
    parameter int SEQ_W = 5,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [SEQ_W-1:0] cfg_pattern;
    logic [CNT_W-1:0] cfg_count;
    logic [TMO_W-1:0] cfg_timeout;
    logic             abort;
    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [CNT_W-1:0] hit_count;
    logic             done_ack;

    modport master (
        output cfg_valid, cfg_pattern, cfg_count, cfg_timeout, abort, done_ack,
        input  cfg_ready, busy, done, status, hit_count
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_count, cfg_timeout, abort, done_ack,
        output cfg_ready, busy, done, status, hit_count
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Run controller for one programmable sequence detector: loads the pattern, clears and
// refills the detector, counts hits until target/timeout/abort, then holds the result.
`timescale 1ns/1ps
module seq_detect_ctrl #(
    parameter int SEQ_W = 5,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    seq_detect_ctrl_if.slave host,
    output logic [SEQ_W-1:0] det_init,
    output logic             det_resetn,
    input  logic             det_seen
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_ARMED = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_MATCH   = 2'b01;
    localparam logic [1:0] RES_TIMEOUT = 2'b10;
    localparam logic [1:0] RES_ABORT   = 2'b11;

    localparam int                FILL_W    = $clog2(SEQ_W + 1);
    localparam logic [FILL_W-1:0] FILL_LOAD = FILL_W'(SEQ_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [1:0]        state_reg,    state_next;
    logic [FILL_W-1:0] fill_reg,     fill_next;
    logic [TMO_W-1:0]  timer_reg,    timer_next;
    logic [TMO_W-1:0]  tmo_reg,      tmo_next;
    logic [CNT_W-1:0]  target_reg,   target_next;
    logic [CNT_W-1:0]  hit_reg,      hit_next;
    logic [1:0]        status_reg,   status_next;
    logic [SEQ_W-1:0]  init_reg,     init_next;
    logic              det_rstn_reg, det_rstn_next;

    logic [CNT_W-1:0]  hit_sat;
    logic [TMO_W:0]    timer_inc;

    assign hit_sat   = (hit_reg == CNT_MAX) ? hit_reg : hit_reg + CNT_W'(1);
    assign timer_inc = {1'b0, timer_reg} + (TMO_W + 1)'(1);

    always_comb begin
        state_next    = state_reg;
        fill_next     = fill_reg;
        timer_next    = timer_reg;
        tmo_next      = tmo_reg;
        target_next   = target_reg;
        hit_next      = hit_reg;
        status_next   = status_reg;
        init_next     = init_reg;
        det_rstn_next = 1'b1;

        case (state_reg)
            S_IDLE: begin
                if (host.cfg_valid) begin
                    init_next     = host.cfg_pattern;
                    target_next   = (host.cfg_count == '0) ? CNT_W'(1) : host.cfg_count;
                    tmo_next      = host.cfg_timeout;
                    hit_next      = '0;
                    status_next   = RES_NONE;
                    fill_next     = FILL_LOAD;
                    // One low cycle clears the detector's shift register.
                    det_rstn_next = 1'b0;
                    state_next    = S_FILL;
                end
            end
            S_FILL: begin
                if (host.abort) begin
                    status_next = RES_ABORT;
                    state_next  = S_DONE;
                end else if (fill_reg == '0) begin
                    timer_next = '0;
                    state_next = S_ARMED;
                end else begin
                    fill_next = fill_reg - FILL_W'(1);
                end
            end
            S_ARMED: begin
                timer_next = timer_inc[TMO_W-1:0];
                if (det_seen) begin
                    hit_next = hit_sat;
                end
                // Abort outranks a match, which outranks a timeout in the same cycle.
                if (host.abort) begin
                    status_next = RES_ABORT;
                    state_next  = S_DONE;
                end else if (det_seen && (hit_sat == target_reg)) begin
                    status_next = RES_MATCH;
                    state_next  = S_DONE;
                end else if ((tmo_reg != '0) && (timer_inc == {1'b0, tmo_reg})) begin
                    status_next = RES_TIMEOUT;
                    state_next  = S_DONE;
                end
            end
            default: begin
                if (host.done_ack) begin
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= S_IDLE;
            fill_reg     <= '0;
            timer_reg    <= '0;
            tmo_reg      <= '0;
            target_reg   <= '0;
            hit_reg      <= '0;
            status_reg   <= RES_NONE;
            init_reg     <= '0;
            det_rstn_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fill_reg     <= fill_next;
            timer_reg    <= timer_next;
            tmo_reg      <= tmo_next;
            target_reg   <= target_next;
            hit_reg      <= hit_next;
            status_reg   <= status_next;
            init_reg     <= init_next;
            det_rstn_reg <= det_rstn_next;
        end
    end

    assign host.cfg_ready = (state_reg == S_IDLE);
    assign host.busy      = (state_reg == S_FILL) || (state_reg == S_ARMED);
    assign host.done      = (state_reg == S_DONE);
    assign host.status    = status_reg;
    assign host.hit_count = hit_reg;
    assign det_init       = init_reg;
    assign det_resetn     = det_rstn_reg;
endmodule
